// File: rtl/rx_sync_decision_multi_if.sv
// Control/data bundle for the multi-channel SYNC correlator: PN load, search
// control, chip streams in; peak report and status pulses out.
interface rx_sync_decision_multi_if #(
  parameter int N_CH   = 4,
  parameter int PN_LEN = 32,
  parameter int SC_W   = 6,
  parameter int WIN_W  = 8,
  parameter int CH_W   = 2
);
  logic [PN_LEN-1:0] sync_pn_in;
  logic              pn_load_in;
  logic              search_start_in;
  logic [WIN_W-1:0]  search_win_in;
  logic [SC_W-1:0]   decision_term;
  logic              data_valid_in;
  logic [N_CH-1:0]   data_corr_in;
  logic [SC_W-1:0]   corr_peak_out;
  logic [CH_W-1:0]   peak_chan_out;
  logic [WIN_W-1:0]  peak_position_out;
  logic              syn_success_out;
  logic              syn_finish_out;
  logic              busy_out;

  modport master (
    output sync_pn_in, pn_load_in, search_start_in, search_win_in, decision_term,
           data_valid_in, data_corr_in,
    input  corr_peak_out, peak_chan_out, peak_position_out, syn_success_out,
           syn_finish_out, busy_out
  );

  modport slave (
    input  sync_pn_in, pn_load_in, search_start_in, search_win_in, decision_term,
           data_valid_in, data_corr_in,
    output corr_peak_out, peak_chan_out, peak_position_out, syn_success_out,
           syn_finish_out, busy_out
  );
endinterface

// File: rtl/rx_sync_decision_multi.sv
// Multi-channel SYNC correlator: per-channel PN match scoring over a search window,
// best-peak tracking across channels, optional early stop on threshold crossing.
module rx_sync_decision_multi #(
  parameter int N_CH       = 4,
  parameter int PN_LEN     = 32,
  parameter int SC_W       = 6,
  parameter int WIN_W      = 8,
  parameter int CH_W       = 2,
  parameter int EARLY_STOP = 0
) (
  input  logic                     logic_clk_in,
  input  logic                     logic_rst_in,
  rx_sync_decision_multi_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SEARCH, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PN_LEN-1:0] pn_q, pn_d;
  logic [PN_LEN-1:0] shreg_q [N_CH];
  logic [PN_LEN-1:0] shreg_d [N_CH];
  logic [WIN_W-1:0]  s_q, s_d, win_q, win_d;
  logic [SC_W-1:0]   thr_q, thr_d;
  logic              elig_p0_q, elig_p0_d;
  logic [WIN_W-1:0]  pos_p0_q, pos_p0_d;
  logic [SC_W-1:0]   score_p1_q [N_CH];
  logic [SC_W-1:0]   score_p1_d [N_CH];
  logic              vld_p1_q, vld_p1_d;
  logic [WIN_W-1:0]  pos_p1_q, pos_p1_d;
  logic [SC_W-1:0]   best_q, best_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [WIN_W-1:0]  bpos_q, bpos_d;
  logic              finish_q, finish_d, success_q, success_d;
  logic [SC_W-1:0]   smax;
  logic [CH_W-1:0]   sch;
  logic              accept, last, hit;

  function automatic logic [SC_W-1:0] popcnt(input logic [PN_LEN-1:0] v);
    logic [SC_W-1:0] n;
    n = '0;
    for (int i = 0; i < PN_LEN; i++) n = n + SC_W'(v[i]);
    return n;
  endfunction

  // stage p1: registered match counts, then the per-sample winner (lowest channel on ties)
  always_comb begin
    for (int c = 0; c < N_CH; c++) score_p1_d[c] = popcnt(~(shreg_q[c] ^ pn_q));
  end

  always_comb begin
    smax = score_p1_q[0];
    sch  = '0;
    for (int c = 1; c < N_CH; c++) begin
      if (score_p1_q[c] > smax) begin
        smax = score_p1_q[c];
        sch  = CH_W'(c);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pn_d      = pn_q;
    shreg_d   = shreg_q;
    s_d       = s_q;
    win_d     = win_q;
    thr_d     = thr_q;
    elig_p0_d = 1'b0;
    pos_p0_d  = s_q;
    vld_p1_d  = elig_p0_q;
    pos_p1_d  = pos_p0_q;
    best_d    = best_q;
    chan_d    = chan_q;
    bpos_d    = bpos_q;
    finish_d  = 1'b0;
    success_d = 1'b0;
    hit       = 1'b0;
    accept    = bus.data_valid_in && (state_q == S_FILL || state_q == S_SEARCH);
    last      = (s_q == win_q - WIN_W'(1));

    // stage p0: shift in chips and tag the sample index for eligibility
    if (accept) begin
      for (int c = 0; c < N_CH; c++) shreg_d[c] = {shreg_q[c][PN_LEN-2:0], bus.data_corr_in[c]};
      s_d       = s_q + WIN_W'(1);
      elig_p0_d = (s_q >= WIN_W'(PN_LEN - 1));
    end

    // stage p2: peak tracking; idle drops stragglers left behind by an early stop
    if (vld_p1_q && state_q != S_IDLE) begin
      if (EARLY_STOP != 0 && smax >= thr_q) begin
        hit    = 1'b1;
        best_d = smax;
        chan_d = sch;
        bpos_d = pos_p1_q;
      end else if (smax > best_q) begin
        best_d = smax;
        chan_d = sch;
        bpos_d = pos_p1_q;
      end
    end

    case (state_q)
      S_IDLE:   if (bus.pn_load_in) pn_d = bus.sync_pn_in;
      S_FILL: begin
        if (accept) begin
          if (last)                               state_d = (s_q >= WIN_W'(PN_LEN - 1)) ? S_FLUSH : S_DONE;
          else if (s_q == WIN_W'(PN_LEN - 1))     state_d = S_SEARCH;
        end
      end
      S_SEARCH: if (accept && last) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_DONE;
      S_DONE: begin
        state_d   = S_IDLE;
        finish_d  = 1'b1;
        success_d = (best_d >= thr_q);
      end
      default:  state_d = S_IDLE;
    endcase

    if (hit) begin
      state_d   = S_IDLE;
      finish_d  = 1'b1;
      success_d = 1'b1;
    end

    // a start from any state wins, silently abandoning a search in progress
    if (bus.search_start_in) begin
      win_d     = bus.search_win_in;
      thr_d     = bus.decision_term;
      for (int c = 0; c < N_CH; c++) shreg_d[c] = '0;
      s_d       = '0;
      elig_p0_d = 1'b0;
      vld_p1_d  = 1'b0;
      best_d    = '0;
      chan_d    = '0;
      bpos_d    = '0;
      finish_d  = 1'b0;
      success_d = 1'b0;
      state_d   = (bus.search_win_in == '0) ? S_DONE : S_FILL;
    end
  end

  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      state_q   <= S_IDLE;
      pn_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        shreg_q[c]    <= '0;
        score_p1_q[c] <= '0;
      end
      s_q       <= '0;
      win_q     <= '0;
      thr_q     <= '0;
      elig_p0_q <= 1'b0;
      pos_p0_q  <= '0;
      vld_p1_q  <= 1'b0;
      pos_p1_q  <= '0;
      best_q    <= '0;
      chan_q    <= '0;
      bpos_q    <= '0;
      finish_q  <= 1'b0;
      success_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pn_q       <= pn_d;
      shreg_q    <= shreg_d;
      score_p1_q <= score_p1_d;
      s_q        <= s_d;
      win_q      <= win_d;
      thr_q      <= thr_d;
      elig_p0_q  <= elig_p0_d;
      pos_p0_q   <= pos_p0_d;
      vld_p1_q   <= vld_p1_d;
      pos_p1_q   <= pos_p1_d;
      best_q     <= best_d;
      chan_q     <= chan_d;
      bpos_q     <= bpos_d;
      finish_q   <= finish_d;
      success_q  <= success_d;
    end
  end

  assign bus.corr_peak_out     = best_q;
  assign bus.peak_chan_out     = chan_q;
  assign bus.peak_position_out = bpos_q;
  assign bus.syn_success_out   = success_q;
  assign bus.syn_finish_out    = finish_q;
  assign bus.busy_out          = (state_q == S_FILL) || (state_q == S_SEARCH) || (state_q == S_FLUSH);

endmodule
